// File: rtl/fp32_sqrt_result_stage.sv
// Registered result stage behind the combinational FP32 sqrt: 2-entry FIFO of {y, exc, tag},
// sticky IEEE flags accumulated on retire, and a wrapping retired-result counter.
module fp32_sqrt_result_stage #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_y,
  input  logic [4:0]       in_exc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [4:0]       out_exc,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flags_clr,
  output logic [4:0]       fflags,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int ENT_W = 32 + 5 + TAG_W;

  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic [4:0]       fflags_q, fflags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  // Handshake terms depend only on registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ent
      localparam bit IDX = (gi == 1);
      logic [ENT_W-1:0] ent_q, ent_d;

      always_comb begin
        ent_d = ent_q;
        if (push && (wr_ptr_q == IDX)) begin
          ent_d = {in_y, in_exc, in_tag};
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ent_q <= '0;
        end else begin
          ent_q <= ent_d;
        end
      end
    end
  endgenerate

  assign head = rd_ptr_q ? g_ent[1].ent_q : g_ent[0].ent_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
    // A clear coinciding with a pop keeps only the retiring entry's flags.
    fflags_d = (flags_clr ? 5'd0 : fflags_q) | (pop ? head[TAG_W +: 5] : 5'd0);
    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      fflags_q <= 5'd0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      fflags_q <= fflags_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_y       = head[ENT_W-1 -: 32];
  assign out_exc     = head[TAG_W +: 5];
  assign out_tag     = head[TAG_W-1:0];
  assign fflags      = fflags_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_fp32_sqrt_result_stage.sv
// Scoreboard bench for fp32_sqrt_result_stage: directed stimulus pushes expectations into a queue,
// a negedge monitor compares the DUT against the queue head, flag and counter models.
module tb_fp32_sqrt_result_stage;

  typedef struct packed {
    logic [31:0] y;
    logic [4:0]  e;
    logic [3:0]  t;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_y = '0;
  logic [4:0]  in_exc = '0;
  logic [3:0]  in_tag = '0;
  logic        out_ready = 1'b0;
  logic        flags_clr = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_y;
  logic [4:0]  out_exc, fflags;
  logic [3:0]  out_tag;
  logic [15:0] retired_cnt;

  logic        in_ready4, out_valid4;
  logic [31:0] out_y4;
  logic [4:0]  out_exc4, fflags4;
  logic [3:0]  out_tag4;
  logic [3:0]  cnt4;

  int errors = 0;
  int checks = 0;

  ent_t        sb_q[$];
  logic [4:0]  m_ff  = '0;
  logic [31:0] m_cnt = '0;

  always #5 clk = ~clk;

  fp32_sqrt_result_stage #(.TAG_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_exc(in_exc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_exc(out_exc), .out_tag(out_tag),
    .flags_clr(flags_clr), .fflags(fflags), .retired_cnt(retired_cnt)
  );

  fp32_sqrt_result_stage #(.TAG_W(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4), .in_y(in_y), .in_exc(in_exc), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready), .out_y(out_y4), .out_exc(out_exc4), .out_tag(out_tag4),
    .flags_clr(flags_clr), .fflags(fflags4), .retired_cnt(cnt4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT state against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_fflags", fflags, 5'd0);
      chk("rst_cnt", retired_cnt, 16'd0);
      chk("rst_out_y", out_y, 32'd0);
      sb_q.delete();
      m_ff  = '0;
      m_cnt = '0;
    end else begin
      logic push, pop;
      ent_t head;
      head = '0;
      chk("in_ready", in_ready, sb_q.size() < 2);
      chk("out_valid", out_valid, sb_q.size() != 0);
      chk("fflags", fflags, m_ff);
      chk("retired_cnt", retired_cnt, m_cnt[15:0]);
      chk("retired_cnt4", cnt4, m_cnt[3:0]);
      if (sb_q.size() != 0) begin
        head = sb_q[0];
        chk("out_y", out_y, head.y);
        chk("out_exc", out_exc, head.e);
        chk("out_tag", out_tag, head.t);
      end
      push = in_valid && (sb_q.size() < 2);
      pop  = (sb_q.size() != 0) && out_ready;
      m_ff = (flags_clr ? 5'd0 : m_ff) | (pop ? head.e : 5'd0);
      if (pop) begin
        void'(sb_q.pop_front());
        m_cnt = m_cnt + 1;
      end
      if (push) sb_q.push_back('{y: in_y, e: in_exc, t: in_tag});
    end
  end

  task automatic step(input logic v, input logic [31:0] y, input logic [4:0] e,
                      input logic [3:0] t, input logic ordy, input logic clr);
    in_valid  = v;
    in_y      = y;
    in_exc    = e;
    in_tag    = t;
    out_ready = ordy;
    flags_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Reset mid-stream with two entries buffered.
    step(1, 32'h11111111, 5'd0, 4'd7, 0, 0);
    step(1, 32'h22222222, 5'd1, 4'd8, 0, 0);
    chk("t1_full_in_ready", in_ready, 1'b0);
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    chk("t1_out_valid", out_valid, 1'b0);
    chk("t1_in_ready", in_ready, 1'b1);

    // Single op.
    step(1, 32'h40000000, 5'd0, 4'd3, 1, 0);
    chk("t2_out_y", out_y, 32'h40000000);
    chk("t2_out_tag", out_tag, 4'd3);
    step(0, 0, 0, 0, 1, 0);
    chk("t2_cnt", retired_cnt, 16'd1);

    // Fill and backpressure; third offer must be ignored.
    step(1, 32'h3f800000, 5'd0, 4'd1, 0, 0);
    step(1, 32'h3fc00000, 5'd0, 4'd2, 0, 0);
    chk("t3_in_ready_full", in_ready, 1'b0);
    step(1, 32'hdeadbeef, 5'd0, 4'd9, 0, 0);
    chk("t3_head_tag", out_tag, 4'd1);
    step(0, 0, 0, 0, 1, 0);
    chk("t3_in_ready_after_pop", in_ready, 1'b1);
    chk("t3_second_tag", out_tag, 4'd2);
    step(0, 0, 0, 0, 1, 0);
    chk("t3_empty", out_valid, 1'b0);

    // Sticky flags, then clear coinciding with a pop.
    step(1, 32'h7fc00000, 5'b10000, 4'd4, 1, 0);
    step(1, 32'h3fb504f3, 5'b00001, 4'd5, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t4_fflags", fflags, 5'b10001);
    step(1, 32'h3fb504f3, 5'b00001, 4'd6, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("t4_clr_pop", fflags, 5'b00001);

    // Streaming: one retire per cycle.
    for (int i = 0; i < 20; i++) begin
      step(1, $urandom, 5'd0, 4'(i), 1, 0);
    end
    step(0, 0, 0, 0, 1, 0);
    chk("t5_cnt", retired_cnt, 16'd26);
    chk("t5_cnt4", cnt4, 4'd10);

    // Counter wrap on the narrow instance.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1, 32'h00000100 + 32'(i), 5'd0, 4'(i), 1, 0);
    end
    step(0, 0, 0, 0, 1, 0);
    chk("t6_cnt4_wrap", cnt4, 4'd1);
    chk("t6_cnt", retired_cnt, 16'd17);
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
